ov7670_cfg_seq: RTL

Register-table sequencer that programs the OV7670 over SCCB by feeding `{register, value}` pairs to the existing `i2c` master one transfer at a time. It sits directly upstream of `i2c` inside `camera_top`, taking the debounced `START` pulse and producing the per-transfer `i2c_start` strobe plus address/data. It also inserts the post-soft-reset settling delay the sensor requires, and reports completion or timeout to the top level.

---
 rtl/ov7670_pkg.sv | 60 ++++++
 rtl/ov7670_reg_rom.sv | 74 +++++++
 rtl/ov7670_cfg_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 SCCB configuration sequencer.
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_CHECK    = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_DELAY    = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERROR    = 3'd7
    } cfg_state_t;

    // One register-table entry: {register address, value}.
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] val;
    } cfg_entry_t;

    // Table markers; neither is a legal {reg, val} write in this table.
    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    // OV7670 register addresses.
    localparam logic [7:0] VREF   = 8'h03;
    localparam logic [7:0] COM1   = 8'h04;
    localparam logic [7:0] COM3   = 8'h0C;
    localparam logic [7:0] COM5   = 8'h0E;
    localparam logic [7:0] COM6   = 8'h0F;
    localparam logic [7:0] CLKRC  = 8'h11;
    localparam logic [7:0] COM7   = 8'h12;
    localparam logic [7:0] COM9   = 8'h14;
    localparam logic [7:0] HSTART = 8'h17;
    localparam logic [7:0] HSTOP  = 8'h18;
    localparam logic [7:0] VSTRT  = 8'h19;
    localparam logic [7:0] VSTOP  = 8'h1A;
    localparam logic [7:0] HREF   = 8'h32;
    localparam logic [7:0] TSLB   = 8'h3A;
    localparam logic [7:0] COM13  = 8'h3D;
    localparam logic [7:0] COM14  = 8'h3E;
    localparam logic [7:0] COM15  = 8'h40;
    localparam logic [7:0] MTX1   = 8'h4F;
    localparam logic [7:0] MTX2   = 8'h50;
    localparam logic [7:0] MTX3   = 8'h51;
    localparam logic [7:0] MTX4   = 8'h52;
    localparam logic [7:0] MTX5   = 8'h53;
    localparam logic [7:0] MTX6   = 8'h54;
    localparam logic [7:0] MTXS   = 8'h58;
    localparam logic [7:0] RGB444 = 8'h8C;

    // Build a write entry from an address and a value.
    function automatic cfg_entry_t cfg_wr(input logic [7:0] a, input logic [7:0] v);
        cfg_entry_t e;
        e.addr = a;
        e.val  = v;
        return e;
    endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Synchronous-read register table: RGB565 / QVGA bring-up, or a short
// four-write table without an END marker for index-limit testing.
module ov7670_reg_rom
    import ov7670_pkg::*;
#(
    parameter int unsigned IDX_W      = 6,
    parameter bit          TEST_TABLE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] idx_i,
    output cfg_entry_t       entry_o
);

    cfg_entry_t entry_d;
    cfg_entry_t entry_q;

    // Table lookup; unlisted indices read as END.
    always_comb begin
        entry_d = cfg_entry_t'(CFG_END);
        if (TEST_TABLE) begin
            case (32'(idx_i))
                0:       entry_d = cfg_wr(COM7,  8'h80);
                1:       entry_d = cfg_wr(COM7,  8'h04);
                2:       entry_d = cfg_wr(COM15, 8'hD0);
                3:       entry_d = cfg_wr(CLKRC, 8'h00);
                default: entry_d = cfg_entry_t'(CFG_END);
            endcase
        end else begin
            case (32'(idx_i))
                0:       entry_d = cfg_wr(COM7,   8'h80);  // soft reset
                1:       entry_d = cfg_entry_t'(CFG_DELAY);
                2:       entry_d = cfg_wr(COM7,   8'h04);  // RGB output
                3:       entry_d = cfg_wr(CLKRC,  8'h00);
                4:       entry_d = cfg_wr(COM3,   8'h00);
                5:       entry_d = cfg_wr(COM14,  8'h00);
                6:       entry_d = cfg_wr(RGB444, 8'h00);
                7:       entry_d = cfg_wr(COM1,   8'h00);
                8:       entry_d = cfg_wr(COM15,  8'hD0);  // RGB565, full range
                9:       entry_d = cfg_wr(TSLB,   8'h04);
                10:      entry_d = cfg_wr(COM9,   8'h38);
                11:      entry_d = cfg_wr(MTX1,   8'hB3);
                12:      entry_d = cfg_wr(MTX2,   8'hB3);
                13:      entry_d = cfg_wr(MTX3,   8'h00);
                14:      entry_d = cfg_wr(MTX4,   8'h3D);
                15:      entry_d = cfg_wr(MTX5,   8'hA7);
                16:      entry_d = cfg_wr(MTX6,   8'hE4);
                17:      entry_d = cfg_wr(MTXS,   8'h9E);
                18:      entry_d = cfg_wr(COM13,  8'hC0);
                19:      entry_d = cfg_wr(HSTART, 8'h14);
                20:      entry_d = cfg_wr(HSTOP,  8'h02);
                21:      entry_d = cfg_wr(HREF,   8'h80);
                22:      entry_d = cfg_wr(VSTRT,  8'h03);
                23:      entry_d = cfg_wr(VSTOP,  8'h7B);
                24:      entry_d = cfg_wr(VREF,   8'h0A);
                25:      entry_d = cfg_wr(COM5,   8'h61);
                26:      entry_d = cfg_wr(COM6,   8'h4B);
                27:      entry_d = cfg_wr(COM14,  8'h19);  // QVGA scaling
                28:      entry_d = cfg_wr(COM3,   8'h04);
                29:      entry_d = cfg_entry_t'(CFG_END);
                default: entry_d = cfg_entry_t'(CFG_END);
            endcase
        end
    end

    // Registered read port: data valid one cycle after the index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) entry_q <= '0;
        else         entry_q <= entry_d;
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/ov7670_cfg_seq.sv
// Walks the OV7670 register table and hands one {reg, val} write at a time
// to the SCCB master, inserting settle delays and a per-transfer timeout.
module ov7670_cfg_seq
    import ov7670_pkg::*;
#(
    parameter int unsigned ROM_DEPTH      = 64,
    parameter int unsigned DELAY_CYCLES   = 100_000,
    parameter int unsigned TIMEOUT_CYCLES = 50_000,
    parameter bit          TEST_ROM       = 1'b0
) (
    input  logic       Clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       i2c_busy,
    input  logic       i2c_done,
    output logic       i2c_start,
    output logic [7:0] i2c_reg,
    output logic [7:0] i2c_data,
    output logic       busy,
    output logic       cfg_done,
    output logic       cfg_err
);

    localparam int unsigned IDX_W   = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int unsigned CNT_MAX = (DELAY_CYCLES > TIMEOUT_CYCLES) ? DELAY_CYCLES
                                                                      : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(ROM_DEPTH - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD   = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    cfg_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             i2c_start_q, i2c_start_d;
    logic [7:0]       i2c_reg_q, i2c_reg_d;
    logic [7:0]       i2c_data_q, i2c_data_d;
    logic             busy_q, busy_d;
    logic             cfg_done_q, cfg_done_d;
    logic             cfg_err_q, cfg_err_d;

    cfg_entry_t rom_entry;
    logic       is_end, is_delay, idx_last, cnt_zero;

    // SCCB busy is informational only; the handshake uses i2c_done.
    logic unused_i2c_busy;
    assign unused_i2c_busy = i2c_busy;

    ov7670_reg_rom #(
        .IDX_W      (IDX_W),
        .TEST_TABLE (TEST_ROM)
    ) u_rom (
        .clk_i   (Clk),
        .rst_ni  (rst_n),
        .idx_i   (idx_q),
        .entry_o (rom_entry)
    );

    assign is_end   = (rom_entry == CFG_END);
    assign is_delay = (rom_entry == CFG_DELAY);
    assign idx_last = (idx_q == IDX_LAST);
    assign cnt_zero = (cnt_q == '0);

    // State register.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; the table index never wraps past the last entry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_CHECK;
            ST_CHECK: begin
                if (is_end)        state_d = ST_DONE;
                else if (is_delay) state_d = ST_DELAY;
                else               state_d = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (i2c_done)      state_d = idx_last ? ST_DONE : ST_FETCH;
                else if (cnt_zero) state_d = ST_ERROR;
            end
            ST_DELAY: if (cnt_zero) state_d = idx_last ? ST_DONE : ST_FETCH;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; flags follow the state being entered.
    always_comb begin
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        i2c_reg_d   = i2c_reg_q;
        i2c_data_d  = i2c_data_q;
        i2c_start_d = (state_d == ST_ISSUE);
        busy_d      = (state_d inside {ST_FETCH, ST_CHECK, ST_ISSUE, ST_WAIT_ACK, ST_DELAY});
        cfg_done_d  = (state_d == ST_DONE);
        cfg_err_d   = (state_d == ST_ERROR);
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) idx_d = '0;
            ST_CHECK: begin
                if (is_delay) begin
                    cnt_d = DELAY_LOAD;
                end else if (!is_end) begin
                    i2c_reg_d  = rom_entry.addr;
                    i2c_data_d = rom_entry.val;
                end
            end
            ST_ISSUE: cnt_d = TIMEOUT_LOAD;
            ST_WAIT_ACK: begin
                if (i2c_done) begin
                    if (!idx_last) idx_d = idx_q + IDX_W'(1);
                end else if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DELAY: begin
                if (cnt_zero) begin
                    if (!idx_last) idx_d = idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            cnt_q       <= '0;
            i2c_start_q <= 1'b0;
            i2c_reg_q   <= 8'h00;
            i2c_data_q  <= 8'h00;
            busy_q      <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            i2c_start_q <= i2c_start_d;
            i2c_reg_q   <= i2c_reg_d;
            i2c_data_q  <= i2c_data_d;
            busy_q      <= busy_d;
            cfg_done_q  <= cfg_done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign i2c_start = i2c_start_q;
    assign i2c_reg   = i2c_reg_q;
    assign i2c_data  = i2c_data_q;
    assign busy      = busy_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;

endmodule
